// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Data-memory req/ack port between the memory-access stage and the data memory.
//   mem_req   : request held high until the cycle ack is seen
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data, replicated across the byte lanes
//   mem_wmask : byte enables (zero for loads)
//   mem_ack   : transaction complete; mem_rdata valid in the same cycle
//   mem_rdata : full 32-bit word read from memory
interface mem_access_stage_if #(
  parameter int DWIDTH = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_ack;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
// RV32I memory-access stage. It forms the effective address and runs one
// req/ack transaction per load or store. Load data is lane-aligned and then
// extended. Every other instruction is forwarded to writeback one cycle later.
// While a transaction is outstanding (state WAIT) the stage stalls upstream.
// Ports:
//   me_clk, me_rst           : clock, synchronous active-high reset
//   me_i_*                   : instruction and operands from execute
//   me_o_ce/we/addr_rd/...   : writeback outputs (ce/we/exc are 1-cycle pulses)
//   me_o_stall               : high in every WAIT cycle
//   mem                      : data-memory port (master side)
module mem_access_stage #(
  parameter int AWIDTH       = 5,
  parameter int DWIDTH       = 32,
  parameter int FUNCT_WIDTH  = 3,
  parameter int PC_WIDTH     = 32,
  parameter int OPCODE_WIDTH = 7,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD  = 7'b0000011,
  parameter logic [OPCODE_WIDTH-1:0] OP_STORE = 7'b0100011
) (
  input  logic                    me_clk,
  input  logic                    me_rst,
  input  logic                    me_i_ce,
  input  logic                    me_i_flush,
  input  logic [OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  me_i_funct3,
  input  logic [DWIDTH-1:0]       me_i_data_rs1,
  input  logic [DWIDTH-1:0]       me_i_data_rs2,
  input  logic [11:0]             me_i_imm,
  input  logic [AWIDTH-1:0]       me_i_addr_rd,
  input  logic [DWIDTH-1:0]       me_i_data_rd,
  input  logic                    me_i_we,
  input  logic [PC_WIDTH-1:0]     me_i_pc,
  output logic                    me_o_ce,
  output logic [AWIDTH-1:0]       me_o_addr_rd,
  output logic [DWIDTH-1:0]       me_o_data_rd,
  output logic                    me_o_we,
  output logic [PC_WIDTH-1:0]     me_o_pc,
  output logic                    me_o_exc,
  output logic                    me_o_stall,
  mem_access_stage_if.master      mem
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic              mem_we_q, mem_we_d;
  logic [DWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              is_load_q, is_load_d;
  logic [FUNCT_WIDTH-1:0] funct3_q, funct3_d;
  logic [1:0]        ea_lo_q, ea_lo_d;
  logic [AWIDTH-1:0] rd_q, rd_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  logic                o_ce_q, o_ce_d;
  logic                o_we_q, o_we_d;
  logic                o_exc_q, o_exc_d;
  logic [AWIDTH-1:0]   o_rd_q, o_rd_d;
  logic [DWIDTH-1:0]   o_data_q, o_data_d;
  logic [PC_WIDTH-1:0] o_pc_q, o_pc_d;

  logic [DWIDTH-1:0] ea;
  logic              is_load, is_store, legal, aligned;
  logic [3:0]        st_wmask;
  logic [DWIDTH-1:0] st_wdata;
  logic [DWIDTH-1:0] lane;
  logic [DWIDTH-1:0] load_val;

  assign ea       = me_i_data_rs1 + {{(DWIDTH-12){me_i_imm[11]}}, me_i_imm};
  assign is_load  = (me_i_opcode == OP_LOAD);
  assign is_store = (me_i_opcode == OP_STORE);

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      legal = (me_i_funct3 == 3'b000) || (me_i_funct3 == 3'b001) ||
              (me_i_funct3 == 3'b010) || (me_i_funct3 == 3'b100) ||
              (me_i_funct3 == 3'b101);
    end else if (is_store) begin
      legal = (me_i_funct3 == 3'b000) || (me_i_funct3 == 3'b001) ||
              (me_i_funct3 == 3'b010);
    end
  end

  // funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    aligned = 1'b1;
    if (me_i_funct3[1:0] == 2'b01) aligned = (ea[0] == 1'b0);
    if (me_i_funct3[1:0] == 2'b10) aligned = (ea[1:0] == 2'b00);
  end

  always_comb begin
    st_wmask = 4'b0000;
    if (is_store) begin
      case (me_i_funct3[1:0])
        2'b00:   st_wmask = 4'b0001 << ea[1:0];
        2'b01:   st_wmask = 4'b0011 << {ea[1], 1'b0};
        default: st_wmask = 4'b1111;
      endcase
    end
  end

  // Store data replicated per byte lane so the mask alone selects the bytes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int HB = (gi % 2) * 8;
      assign st_wdata[8*gi +: 8] =
        (me_i_funct3[1:0] == 2'b00) ? me_i_data_rs2[7:0]  :
        (me_i_funct3[1:0] == 2'b01) ? me_i_data_rs2[HB +: 8] :
                                      me_i_data_rs2[8*gi +: 8];
    end
  endgenerate

  assign lane = mem.mem_rdata >> {ea_lo_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{(DWIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{(DWIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_val = {{(DWIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_val = {{(DWIDTH-16){1'b0}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    is_load_d  = is_load_q;
    funct3_d   = funct3_q;
    ea_lo_d    = ea_lo_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    o_ce_d     = 1'b0;
    o_we_d     = 1'b0;
    o_exc_d    = 1'b0;
    o_rd_d     = o_rd_q;
    o_data_d   = o_data_q;
    o_pc_d     = o_pc_q;

    case (state_q)
      S_IDLE: begin
        if (me_i_ce && !me_i_flush) begin
          if (is_load || is_store) begin
            if (legal && aligned) begin
              state_d    = S_WAIT;
              req_d      = 1'b1;
              mem_we_d   = is_store;
              mem_addr_d = {ea[DWIDTH-1:2], 2'b00};
              wdata_d    = is_store ? st_wdata : '0;
              wmask_d    = st_wmask;
              is_load_d  = is_load;
              funct3_d   = me_i_funct3;
              ea_lo_d    = ea[1:0];
              rd_d       = me_i_addr_rd;
              pc_d       = me_i_pc;
            end else begin
              o_exc_d = 1'b1;
              o_pc_d  = me_i_pc;
            end
          end else begin
            o_ce_d   = 1'b1;
            o_we_d   = me_i_we && (me_i_addr_rd != '0);
            o_rd_d   = me_i_addr_rd;
            o_data_d = me_i_data_rd;
            o_pc_d   = me_i_pc;
          end
        end
      end
      S_WAIT: begin
        // Flush is deliberately not looked at here: the access must retire.
        if (mem.mem_ack) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          mem_we_d = 1'b0;
          wmask_d  = 4'b0000;
          o_ce_d   = 1'b1;
          o_rd_d   = rd_q;
          o_pc_d   = pc_q;
          if (is_load_q) begin
            o_data_d = load_val;
            o_we_d   = (rd_q != '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge me_clk) begin
    if (me_rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      wmask_q    <= 4'b0000;
      is_load_q  <= 1'b0;
      funct3_q   <= '0;
      ea_lo_q    <= 2'b00;
      rd_q       <= '0;
      pc_q       <= '0;
      o_ce_q     <= 1'b0;
      o_we_q     <= 1'b0;
      o_exc_q    <= 1'b0;
      o_rd_q     <= '0;
      o_data_q   <= '0;
      o_pc_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      is_load_q  <= is_load_d;
      funct3_q   <= funct3_d;
      ea_lo_q    <= ea_lo_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      o_ce_q     <= o_ce_d;
      o_we_q     <= o_we_d;
      o_exc_q    <= o_exc_d;
      o_rd_q     <= o_rd_d;
      o_data_q   <= o_data_d;
      o_pc_q     <= o_pc_d;
    end
  end

  assign me_o_stall    = (state_q == S_WAIT);
  assign me_o_ce       = o_ce_q;
  assign me_o_we       = o_we_q;
  assign me_o_exc      = o_exc_q;
  assign me_o_addr_rd  = o_rd_q;
  assign me_o_data_rd  = o_data_q;
  assign me_o_pc       = o_pc_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed bench for mem_access_stage: inputs change and outputs are checked
// on the falling clock edge; the DUT registers on the rising edge.
module tb_mem_access_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, flush, we_in;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, drd, pc_in;
  logic [11:0] imm;
  logic [4:0]  rd_in;

  logic        o_ce, o_we, o_exc, o_stall;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_pc;

  int checks   = 0;
  int failures = 0;

  mem_access_stage_if #(.DWIDTH(32)) mif ();

  mem_access_stage dut (
    .me_clk        (clk),
    .me_rst        (rst),
    .me_i_ce       (ce),
    .me_i_flush    (flush),
    .me_i_opcode   (opcode),
    .me_i_funct3   (funct3),
    .me_i_data_rs1 (rs1),
    .me_i_data_rs2 (rs2),
    .me_i_imm      (imm),
    .me_i_addr_rd  (rd_in),
    .me_i_data_rd  (drd),
    .me_i_we       (we_in),
    .me_i_pc       (pc_in),
    .me_o_ce       (o_ce),
    .me_o_addr_rd  (o_rd),
    .me_o_data_rd  (o_data),
    .me_o_we       (o_we),
    .me_o_pc       (o_pc),
    .me_o_exc      (o_exc),
    .me_o_stall    (o_stall),
    .mem           (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [11:0] im, input logic [4:0] rd,
                         input logic [31:0] d, input logic w, input logic [31:0] pc);
    ce = 1'b1; opcode = op; funct3 = f3; rs1 = r1; rs2 = r2;
    imm = im; rd_in = rd; drd = d; we_in = w; pc_in = pc;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; flush = 1'b0; we_in = 1'b0; opcode = '0; funct3 = '0;
    rs1 = '0; rs2 = '0; drd = '0; pc_in = '0; imm = '0; rd_in = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    chk("rst_ce", {31'b0, o_ce}, 32'd0);
    chk("rst_req", {31'b0, mif.mem_req}, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    $display("txn reset");
    rst = 1'b0;

    // ALU pass-through, then rd=0 suppresses the write
    present(OP_RTYPE, 3'b000, 0, 0, 0, 5'd3, 32'h5, 1'b1, 32'h100);
    tick();
    chk("alu_ce", {31'b0, o_ce}, 32'd1);
    chk("alu_data", o_data, 32'h5);
    chk("alu_rd", {27'b0, o_rd}, 32'd3);
    chk("alu_we", {31'b0, o_we}, 32'd1);
    chk("alu_stall", {31'b0, o_stall}, 32'd0);
    chk("alu_req", {31'b0, mif.mem_req}, 32'd0);
    chk("alu_pc", o_pc, 32'h100);
    $display("txn alu rd=3 data=%h", o_data);
    present(OP_RTYPE, 3'b000, 0, 0, 0, 5'd0, 32'h9, 1'b1, 32'h104);
    tick();
    chk("alu0_ce", {31'b0, o_ce}, 32'd1);
    chk("alu0_we", {31'b0, o_we}, 32'd0);
    $display("txn alu rd=0");
    ce = 1'b0;
    tick();
    chk("alu_pulse_ce", {31'b0, o_ce}, 32'd0);

    // LB at EA 0x1003, ack in the third WAIT cycle
    present(OP_LOAD, 3'b000, 32'h1000, 0, 12'h003, 5'd5, 0, 1'b0, 32'h108);
    tick();
    ce = 1'b0;
    chk("lb_req", {31'b0, mif.mem_req}, 32'd1);
    chk("lb_stall", {31'b0, o_stall}, 32'd1);
    chk("lb_addr", mif.mem_addr, 32'h1000);
    chk("lb_memwe", {31'b0, mif.mem_we}, 32'd0);
    chk("lb_wmask", {28'b0, mif.mem_wmask}, 32'd0);
    tick();
    chk("lb_wait2_stall", {31'b0, o_stall}, 32'd1);
    tick();
    chk("lb_wait3_req", {31'b0, mif.mem_req}, 32'd1);
    chk("lb_wait3_stall", {31'b0, o_stall}, 32'd1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80FF1234;
    tick();
    mif.mem_ack = 1'b0;
    chk("lb_data", o_data, 32'hFFFFFF80);
    chk("lb_we", {31'b0, o_we}, 32'd1);
    chk("lb_ce", {31'b0, o_ce}, 32'd1);
    chk("lb_rd", {27'b0, o_rd}, 32'd5);
    chk("lb_pc", o_pc, 32'h108);
    chk("lb_req_drop", {31'b0, mif.mem_req}, 32'd0);
    chk("lb_stall_drop", {31'b0, o_stall}, 32'd0);
    $display("txn lb data=%h", o_data);
    tick();
    chk("lb_pulse_ce", {31'b0, o_ce}, 32'd0);

    // LBU same access, ack in first WAIT cycle
    present(OP_LOAD, 3'b100, 32'h1000, 0, 12'h003, 5'd5, 0, 1'b0, 32'h10C);
    tick();
    ce = 1'b0;
    chk("lbu_req", {31'b0, mif.mem_req}, 32'd1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80FF1234;
    tick();
    mif.mem_ack = 1'b0;
    chk("lbu_data", o_data, 32'h00000080);
    chk("lbu_ce", {31'b0, o_ce}, 32'd1);
    $display("txn lbu data=%h", o_data);

    // LH with negative offset: EA = 0x1004 - 2 = 0x1002, upper half
    present(OP_LOAD, 3'b001, 32'h1004, 0, 12'hFFE, 5'd7, 0, 1'b0, 32'h110);
    tick();
    ce = 1'b0;
    chk("lh_addr", mif.mem_addr, 32'h1000);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80011234;
    tick();
    mif.mem_ack = 1'b0;
    chk("lh_data", o_data, 32'hFFFF8001);
    chk("lh_rd", {27'b0, o_rd}, 32'd7);
    $display("txn lh data=%h", o_data);

    // SH at EA 0x2002
    present(OP_STORE, 3'b001, 32'h2000, 32'h0000ABCD, 12'h002, 5'd0, 0, 1'b0, 32'h114);
    tick();
    ce = 1'b0;
    chk("sh_memwe", {31'b0, mif.mem_we}, 32'd1);
    chk("sh_wmask", {28'b0, mif.mem_wmask}, 32'hC);
    chk("sh_wdata", mif.mem_wdata, 32'hABCDABCD);
    chk("sh_addr", mif.mem_addr, 32'h2000);
    chk("sh_stall", {31'b0, o_stall}, 32'd1);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    chk("sh_ce", {31'b0, o_ce}, 32'd1);
    chk("sh_we", {31'b0, o_we}, 32'd0);
    chk("sh_stall_drop", {31'b0, o_stall}, 32'd0);
    $display("txn sh mask=c");

    // SB at EA 0x3001
    present(OP_STORE, 3'b000, 32'h3000, 32'h12345678, 12'h001, 5'd0, 0, 1'b0, 32'h118);
    tick();
    ce = 1'b0;
    chk("sb_wmask", {28'b0, mif.mem_wmask}, 32'h2);
    chk("sb_wdata", mif.mem_wdata, 32'h78787878);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    chk("sb_ce", {31'b0, o_ce}, 32'd1);
    $display("txn sb mask=2");

    // SW full word
    present(OP_STORE, 3'b010, 32'h3004, 32'hCAFEF00D, 12'h000, 5'd0, 0, 1'b0, 32'h11C);
    tick();
    ce = 1'b0;
    chk("sw_wmask", {28'b0, mif.mem_wmask}, 32'hF);
    chk("sw_wdata", mif.mem_wdata, 32'hCAFEF00D);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    $display("txn sw");

    // Misaligned LW at EA 0x1002
    present(OP_LOAD, 3'b010, 32'h1000, 0, 12'h002, 5'd4, 0, 1'b0, 32'h200);
    tick();
    ce = 1'b0;
    chk("mis_req", {31'b0, mif.mem_req}, 32'd0);
    chk("mis_exc", {31'b0, o_exc}, 32'd1);
    chk("mis_pc", o_pc, 32'h200);
    chk("mis_ce", {31'b0, o_ce}, 32'd0);
    chk("mis_we", {31'b0, o_we}, 32'd0);
    chk("mis_stall", {31'b0, o_stall}, 32'd0);
    $display("txn misaligned lw");
    tick();
    chk("mis_exc_pulse", {31'b0, o_exc}, 32'd0);

    // Illegal load funct3 011, aligned address
    present(OP_LOAD, 3'b011, 32'h1000, 0, 12'h000, 5'd4, 0, 1'b0, 32'h204);
    tick();
    ce = 1'b0;
    chk("ill_ld_exc", {31'b0, o_exc}, 32'd1);
    chk("ill_ld_req", {31'b0, mif.mem_req}, 32'd0);
    $display("txn illegal load");

    // Illegal store funct3 100
    present(OP_STORE, 3'b100, 32'h1000, 0, 12'h000, 5'd0, 0, 1'b0, 32'h208);
    tick();
    ce = 1'b0;
    chk("ill_st_exc", {31'b0, o_exc}, 32'd1);
    chk("ill_st_pc", o_pc, 32'h208);
    $display("txn illegal store");

    // Flushed load in IDLE is dropped
    present(OP_LOAD, 3'b010, 32'h4000, 0, 12'h000, 5'd9, 0, 1'b0, 32'h300);
    flush = 1'b1;
    tick();
    ce = 1'b0; flush = 1'b0;
    chk("fl_req", {31'b0, mif.mem_req}, 32'd0);
    chk("fl_ce", {31'b0, o_ce}, 32'd0);
    chk("fl_stall", {31'b0, o_stall}, 32'd0);
    $display("txn flushed load");

    // Flush during WAIT does not stop retirement
    present(OP_LOAD, 3'b010, 32'h4000, 0, 12'h000, 5'd9, 0, 1'b0, 32'h304);
    tick();
    flush = 1'b1;
    chk("flw_req", {31'b0, mif.mem_req}, 32'd1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
    tick();
    mif.mem_ack = 1'b0; ce = 1'b0; flush = 1'b0;
    chk("flw_ce", {31'b0, o_ce}, 32'd1);
    chk("flw_we", {31'b0, o_we}, 32'd1);
    chk("flw_data", o_data, 32'hDEADBEEF);
    $display("txn flush-in-wait lw data=%h", o_data);

    // Reset two cycles after req, then a late ack is ignored
    present(OP_LOAD, 3'b010, 32'h5000, 0, 12'h000, 5'd6, 0, 1'b0, 32'h400);
    tick();
    ce = 1'b0;
    chk("rw_req", {31'b0, mif.mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req0", {31'b0, mif.mem_req}, 32'd0);
    chk("rw_stall0", {31'b0, o_stall}, 32'd0);
    chk("rw_data0", o_data, 32'd0);
    chk("rw_pc0", o_pc, 32'd0);
    chk("rw_rd0", {27'b0, o_rd}, 32'd0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h11111111;
    tick();
    mif.mem_ack = 1'b0;
    chk("rw_ack_ignored_ce", {31'b0, o_ce}, 32'd0);
    chk("rw_ack_ignored_we", {31'b0, o_we}, 32'd0);
    $display("txn reset-in-wait");
    present(OP_RTYPE, 3'b000, 0, 0, 0, 5'd1, 32'h77, 1'b1, 32'h408);
    tick();
    ce = 1'b0;
    chk("post_add_ce", {31'b0, o_ce}, 32'd1);
    chk("post_add_data", o_data, 32'h77);
    chk("post_add_we", {31'b0, o_we}, 32'd1);
    $display("txn add after reset data=%h", o_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the RV32I pipeline. It sits directly downstream of the execute stage and directly upstream of writeback. It forms load/store addresses and runs a req/ack transaction on the data-memory port. Loads are aligned and sign- or zero-extended, stores get a byte mask, and every other instruction passes through with one cycle of latency. While a memory transaction is outstanding, the stage stalls upstream.

## Interface
- AWIDTH, 5, register address width
- DWIDTH, 32, data width
- FUNCT_WIDTH, 3, funct3 width
- PC_WIDTH, 32, PC width
- me_clk  in  1  clock, all state on rising edge
- me_rst  in  1  reset, synchronous, active-high
- me_i_ce  in  1  valid instruction from execute
- me_i_flush  in  1  kill incoming instruction
- me_i_opcode  in  `OPCODE_WIDTH  opcode (`LOAD_WORD, `STORE_WORD, others pass through)
- me_i_funct3  in  FUNCT_WIDTH  access size/sign
- me_i_data_rs1  in  DWIDTH  base address
- me_i_data_rs2  in  DWIDTH  store data
- me_i_imm  in  12  address offset, sign-extended internally
- me_i_addr_rd  in  AWIDTH  destination register
- me_i_data_rd  in  DWIDTH  execute result (ALU/link/LUI/AUIPC)
- me_i_we  in  1  execute result writes rd
- me_i_pc  in  PC_WIDTH  instruction PC
- me_o_ce  out  1  valid to writeback (1-cycle pulse per instruction)
- me_o_addr_rd  out  AWIDTH  destination register
- me_o_data_rd  out  DWIDTH  writeback data
- me_o_we  out  1  register write enable
- me_o_pc  out  PC_WIDTH  PC of retiring/faulting instruction
- me_o_exc  out  1  misaligned/illegal access pulse
- me_o_stall  out  1  upstream hold
- me_o_mem_req  out  1  memory request
- me_o_mem_we  out  1  1 = store
- me_o_mem_addr  out  DWIDTH  word-aligned address
- me_o_mem_wdata  out  DWIDTH  replicated store data
- me_o_mem_wmask  out  4  byte enables
- me_i_mem_ack  in  1  transaction complete; rdata valid this cycle
- me_i_mem_rdata  in  DWIDTH  load word

## Operation
- Effective address: EA = me_i_data_rs1 + sext(me_i_imm), modulo 2^32. Mem address = {EA[31:2], 2'b00}.
- FSM has two states: IDLE and WAIT. Reset puts the FSM in IDLE and forces every output to 0.
- In IDLE, an instruction is accepted when me_i_ce=1 and me_i_flush=0.
  - Non-memory opcode: register addr_rd, data_rd and pc. me_o_we = me_i_we && addr_rd!=0. me_o_ce=1 next cycle.
  - Load or store, aligned and legal: register request fields, set me_o_mem_req=1, go to WAIT.
  - Misaligned or illegal access: no request. Next cycle me_o_exc=1, me_o_pc = instruction PC, me_o_ce=0, me_o_we=0.
- Alignment rules:
  - Halfword (funct3 001/101) requires EA[0]=0.
  - Word (010) requires EA[1:0]=0.
  - Loads with funct3 011/110/111 and stores with funct3 other than 000/001/010 are illegal.
- Store mask:
  - SB: 4'b0001<<EA[1:0], wdata = {4{rs2[7:0]}}.
  - SH: 4'b0011<<{EA[1],1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: 4'b1111, wdata = rs2.
  - Loads drive wmask=0, mem_we=0.
- In WAIT, req, we, addr, wdata and wmask are held stable until ack.
  - On ack: req drops at the next edge and the FSM returns to IDLE.
  - Load on ack: lane = rdata >> (8*EA[1:0]). LB/LH sign-extend, LBU/LHU zero-extend from bit 7 or 15, LW passes through. Next cycle me_o_data_rd carries the result, me_o_we = (rd!=0), me_o_ce=1.
  - Store on ack: next cycle me_o_ce=1, me_o_we=0.
- me_i_flush is ignored in WAIT. The outstanding transaction always completes and retires.
- me_o_exc, me_o_ce and me_o_we are single-cycle pulses. They are 0 in every other cycle.

## Timing
- Pass-through latency is 1 cycle: accept at edge N, outputs valid after edge N.
- me_o_mem_req is registered and rises at the edge that accepts the load/store.
- ack may arrive in the first WAIT cycle. The minimum memory occupancy is then 2 cycles: accept cycle plus ack cycle. Writeback output follows 1 cycle after ack.
- me_o_stall = (state==WAIT), combinational from state. It is high in every WAIT cycle, including the ack cycle, and low in IDLE.
- Upstream must hold its outputs while me_o_stall=1. The next instruction is accepted on the first IDLE cycle.
- ack while state is IDLE is ignored.
- Reset mid-WAIT: at the reset edge req, stall and all outputs go to 0 and the FSM goes to IDLE. The abandoned transaction is not retried.
- Reset has priority over ack, flush and ce.

## Test plan
- ALU pass-through: ce=1, opcode RTYPE, data_rd=0x00000005, rd=3, we=1 -> next cycle ce=1, data_rd=5, addr_rd=3, we=1, stall=0, req=0. Repeat with rd=0 -> we=0.
- LB sign extension: rs1=0x1000, imm=0x003, funct3=000 -> mem_addr=0x1000, req=1, stall=1. Ack after 3 wait cycles with rdata=0x80FF1234 -> data_rd=0xFFFFFF80, we=1, ce=1 one cycle. Same access as LBU -> data_rd=0x00000080.
- SH: rs1=0x2000, imm=0x002, rs2=0x0000ABCD -> mem_we=1, wmask=4'b1100, wdata=0xABCDABCD, addr=0x2000. Ack in first WAIT cycle -> ce=1, we=0, total 2 stall-free-to-IDLE cycles.
- Misaligned LW: EA=0x1002 -> req never asserts, exc=1 one cycle, pc echoed, ce=0, we=0. LW funct3=011 -> exc=1.
- Flush: load presented with flush=1 in IDLE -> no req, ce=0. Flush asserted during WAIT -> ack still retires the load with we=1.
- Reset in WAIT: assert me_rst two cycles after req -> next cycle req=0, stall=0, all outputs 0. A later ack is ignored, and a following ADD passes through normally.
